fsmc_cmd_assembler: RTL and testbench

- Upstream stage of the FSMC command decoder.
- Bridges the asynchronous STM32 FSMC 16-bit bus into the clk domain.
- Collects five 16-bit shadow words and, on a keyed commit write, presents them atomically as the 80-bit temp word with a one-cycle temp_valid strobe.
- Provides MCU readback of the shadow words and of a status word.

---
 rtl/fsmc_cmd_pkg.sv | 31 +++
 rtl/fsmc_sync.sv | 30 +++
 rtl/fsmc_cmd_assembler.sv | 169 ++++++++++++++++
 tb/tb_fsmc_cmd_assembler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsmc_cmd_pkg.sv
// Shared constants and types for the FSMC command assembler: the register map,
// the commit key, the bus FSM states and the status word layout.
package fsmc_cmd_pkg;

    localparam int TEMP_W     = 80;
    localparam int WORD_W     = 16;
    localparam int NUM_SHADOW = 5;

    localparam logic [15:0] COMMIT_KEY_DEF = 16'hA5A5;

    localparam int ADDR_W0     = 0;
    localparam int ADDR_W1     = 1;
    localparam int ADDR_W2     = 2;
    localparam int ADDR_W3     = 3;
    localparam int ADDR_W4     = 4;
    localparam int ADDR_COMMIT = 5;
    localparam int ADDR_STATUS = 6;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WR_ACTIVE = 2'd1,
        ST_WR_APPLY  = 2'd2,
        ST_RD_ACTIVE = 2'd3
    } fsm_state_t;

    // Status readback: sticky error flag in the MSB, commit counter in the low byte.
    function automatic logic [WORD_W-1:0] status_word(input logic err, input logic [7:0] cnt);
        return {err, 7'b0, cnt};
    endfunction

endpackage

// File: rtl/fsmc_sync.sv
// Multi-bit flop-chain synchroniser with configurable depth and reset value.
module fsmc_sync #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= RST_VAL;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/fsmc_cmd_assembler.sv
// Bridges the asynchronous FSMC bus into clk, collects five shadow words and
// publishes them atomically as an 80-bit command on a keyed commit write.
module fsmc_cmd_assembler
    import fsmc_cmd_pkg::*;
#(
    parameter int          ADDR_W      = 3,
    parameter logic [15:0] COMMIT_KEY  = COMMIT_KEY_DEF,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fsmc_ne,
    input  logic              fsmc_nwe,
    input  logic              fsmc_noe,
    input  logic [ADDR_W-1:0] fsmc_a,
    input  logic [15:0]       fsmc_d_i,
    output logic [15:0]       fsmc_d_o,
    output logic              fsmc_d_oe,
    output logic [TEMP_W-1:0] temp,
    output logic              temp_valid,
    output logic              cmd_err,
    output fsm_state_t        fsm_state
);

    logic              ne_s;
    logic              nwe_s;
    logic              noe_s;
    logic [ADDR_W-1:0] a_s;
    logic [15:0]       d_s;

    // Strobes reset to their inactive (high) level so reset never looks like an access.
    fsmc_sync #(
        .WIDTH   (3),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (3'b111)
    ) u_ctrl_sync (
        .clk (clk),
        .rst (rst),
        .d   ({fsmc_ne, fsmc_nwe, fsmc_noe}),
        .q   ({ne_s, nwe_s, noe_s})
    );

    fsmc_sync #(
        .WIDTH   (ADDR_W + 16),
        .STAGES  (SYNC_STAGES),
        .RST_VAL ('0)
    ) u_bus_sync (
        .clk (clk),
        .rst (rst),
        .d   ({fsmc_a, fsmc_d_i}),
        .q   ({a_s, d_s})
    );

    fsm_state_t        state;
    fsm_state_t        state_next;
    logic              latch_en;
    logic              apply_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic [15:0]       shadow [NUM_SHADOW];
    logic [7:0]        commit_cnt;
    logic [15:0]       rd_word;
    logic [TEMP_W-1:0] temp_next;

    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        latch_en   = 1'b0;
        apply_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!ne_s && !nwe_s) begin
                    state_next = ST_WR_ACTIVE;
                end else if (!ne_s && !noe_s) begin
                    state_next = ST_RD_ACTIVE;
                end
            end
            ST_WR_ACTIVE: begin
                latch_en = 1'b1;
                if (nwe_s || ne_s) begin
                    state_next = ST_WR_APPLY;
                end
            end
            ST_WR_APPLY: begin
                apply_en   = 1'b1;
                state_next = ST_IDLE;
            end
            ST_RD_ACTIVE: begin
                if (ne_s || noe_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_SHADOW; i++) begin
            if (a_s == ADDR_W'(i)) begin
                rd_word = shadow[i];
            end
        end
        if (a_s == ADDR_W'(ADDR_STATUS)) begin
            rd_word = status_word(cmd_err, commit_cnt);
        end
    end

    always_comb begin
        temp_next = '0;
        for (int i = 0; i < NUM_SHADOW; i++) begin
            temp_next[i*WORD_W +: WORD_W] = shadow[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_addr    <= '0;
            wr_data    <= '0;
            for (int i = 0; i < NUM_SHADOW; i++) begin
                shadow[i] <= '0;
            end
            temp       <= '0;
            temp_valid <= 1'b0;
            cmd_err    <= 1'b0;
            commit_cnt <= '0;
            fsmc_d_oe  <= 1'b0;
            fsmc_d_o   <= '0;
        end else begin
            temp_valid <= 1'b0;
            if (latch_en) begin
                wr_addr <= a_s;
                wr_data <= d_s;
            end
            if (apply_en) begin
                for (int i = 0; i < NUM_SHADOW; i++) begin
                    if (wr_addr == ADDR_W'(i)) begin
                        shadow[i] <= wr_data;
                    end
                end
                if (wr_addr == ADDR_W'(ADDR_COMMIT)) begin
                    if (wr_data == COMMIT_KEY) begin
                        temp       <= temp_next;
                        temp_valid <= 1'b1;
                        commit_cnt <= commit_cnt + 8'd1;
                    end else begin
                        cmd_err <= 1'b1;
                    end
                end
                if (wr_addr == ADDR_W'(ADDR_STATUS)) begin
                    cmd_err <= 1'b0;
                end
            end
            // Output enable tracks the next state so it drops on the same edge the read ends.
            fsmc_d_oe <= (state_next == ST_RD_ACTIVE);
            fsmc_d_o  <= (state_next == ST_RD_ACTIVE) ? rd_word : '0;
        end
    end

endmodule

// File: tb/tb_fsmc_cmd_assembler.sv
// Directed bench for fsmc_cmd_assembler: table of bus accesses with expected
// results, then hand-written strobe-overlap, reset-mid-access and counter-wrap sequences.
`timescale 1ns/1ps
module tb_fsmc_cmd_assembler;
    import fsmc_cmd_pkg::*;

    logic        clk;
    logic        rst;
    logic        fsmc_ne;
    logic        fsmc_nwe;
    logic        fsmc_noe;
    logic [2:0]  fsmc_a;
    logic [15:0] fsmc_d_i;
    logic [15:0] fsmc_d_o;
    logic        fsmc_d_oe;
    logic [79:0] temp;
    logic        temp_valid;
    logic        cmd_err;
    fsm_state_t  fsm_state;

    int checks   = 0;
    int failures = 0;

    fsmc_cmd_assembler dut (
        .clk        (clk),
        .rst        (rst),
        .fsmc_ne    (fsmc_ne),
        .fsmc_nwe   (fsmc_nwe),
        .fsmc_noe   (fsmc_noe),
        .fsmc_a     (fsmc_a),
        .fsmc_d_i   (fsmc_d_i),
        .fsmc_d_o   (fsmc_d_o),
        .fsmc_d_oe  (fsmc_d_oe),
        .temp       (temp),
        .temp_valid (temp_valid),
        .cmd_err    (cmd_err),
        .fsm_state  (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks: all bus changes happen on the falling edge
    task automatic bus_write(input logic [2:0] addr, input logic [15:0] data, input logic with_noe,
                             output logic [7:0] tv_hist, output logic oe_seen);
        tv_hist = '0;
        oe_seen = 1'b0;
        @(negedge clk);
        fsmc_a   = addr;
        fsmc_d_i = data;
        fsmc_ne  = 1'b0;
        fsmc_nwe = 1'b0;
        if (with_noe) fsmc_noe = 1'b0;
        repeat (4) begin
            @(negedge clk);
            oe_seen |= fsmc_d_oe;
        end
        fsmc_nwe = 1'b1;
        fsmc_noe = 1'b1;
        fsmc_ne  = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            tv_hist[i] = temp_valid;
            oe_seen |= fsmc_d_oe;
            if (i == 2) begin
                fsmc_a   = 3'd7;
                fsmc_d_i = 16'($urandom);
            end
        end
    endtask

    // oe_trace: [0] one cycle into the strobe, [1] mid-strobe, [2] three cycles after release
    task automatic bus_read(input logic [2:0] addr, output logic [15:0] data, output logic [2:0] oe_trace);
        @(negedge clk);
        fsmc_a   = addr;
        fsmc_ne  = 1'b0;
        fsmc_noe = 1'b0;
        @(negedge clk);
        oe_trace[0] = fsmc_d_oe;
        repeat (3) @(negedge clk);
        data        = fsmc_d_o;
        oe_trace[1] = fsmc_d_oe;
        @(negedge clk);
        fsmc_ne  = 1'b1;
        fsmc_noe = 1'b1;
        repeat (3) @(negedge clk);
        oe_trace[2] = fsmc_d_oe;
    endtask

    typedef struct {
        logic        is_read;
        logic [2:0]  addr;
        logic [15:0] data;
        logic [15:0] exp_rd;
        logic        exp_pulse;
        logic [79:0] exp_temp;
        logic        exp_err;
    } vec_t;

    vec_t vecs [40];
    int   n_vec = 0;

    task automatic add_w(input logic [2:0] addr, input logic [15:0] data, input logic pulse,
                         input logic [79:0] t, input logic err);
        vecs[n_vec] = '{1'b0, addr, data, 16'h0, pulse, t, err};
        n_vec++;
    endtask

    task automatic add_r(input logic [2:0] addr, input logic [15:0] exp_rd);
        vecs[n_vec] = '{1'b1, addr, 16'h0, exp_rd, 1'b0, 80'h0, 1'b0};
        n_vec++;
    endtask

    localparam logic [79:0] T1 = 80'h5555_4444_3333_2222_1111;
    localparam logic [79:0] T2 = 80'h5555_4444_BEEF_9999_1111;

    // scoreboard: expected status words for the counter-wrap sequence
    logic [15:0] exp_q [$];

    initial begin
        logic [7:0]  hist;
        logic        oe_seen;
        logic [15:0] rd;
        logic [2:0]  oe_tr;
        logic        tv_any;
        int          good_commits;

        rst      = 1'b0;
        fsmc_ne  = 1'b1;
        fsmc_nwe = 1'b1;
        fsmc_noe = 1'b1;
        fsmc_a   = '0;
        fsmc_d_i = '0;

        add_w(3'd0, 16'h1111, 1'b0, 80'h0, 1'b0);
        add_w(3'd1, 16'h2222, 1'b0, 80'h0, 1'b0);
        add_w(3'd2, 16'h3333, 1'b0, 80'h0, 1'b0);
        add_w(3'd3, 16'h4444, 1'b0, 80'h0, 1'b0);
        add_w(3'd4, 16'h5555, 1'b0, 80'h0, 1'b0);
        add_w(3'd5, 16'hA5A5, 1'b1, T1, 1'b0);
        add_r(3'd6, 16'h0001);
        add_r(3'd0, 16'h1111);
        add_r(3'd1, 16'h2222);
        add_r(3'd2, 16'h3333);
        add_r(3'd3, 16'h4444);
        add_r(3'd4, 16'h5555);
        add_r(3'd5, 16'h0000);
        add_r(3'd7, 16'h0000);
        add_w(3'd1, 16'h9999, 1'b0, T1, 1'b0);
        add_w(3'd5, 16'h1234, 1'b0, T1, 1'b1);
        add_r(3'd6, 16'h8001);
        add_r(3'd1, 16'h9999);
        add_w(3'd6, 16'h0000, 1'b0, T1, 1'b0);
        add_r(3'd6, 16'h0001);
        add_w(3'd2, 16'hBEEF, 1'b0, T1, 1'b0);
        add_r(3'd2, 16'hBEEF);
        add_w(3'd5, 16'hA5A5, 1'b1, T2, 1'b0);
        add_w(3'd5, 16'hA5A5, 1'b1, T2, 1'b0);
        add_r(3'd6, 16'h0003);
        add_w(3'd5, 16'h0000, 1'b0, T2, 1'b1);
        add_w(3'd6, 16'hABCD, 1'b0, T2, 1'b0);
        add_w(3'd7, 16'hFFFF, 1'b0, T2, 1'b0);
        add_r(3'd3, 16'h4444);
        add_r(3'd6, 16'h0003);

        repeat (3) @(negedge clk);
        check("rst_temp", temp, 80'h0);
        check("rst_temp_valid", 80'(temp_valid), 80'h0);
        check("rst_cmd_err", 80'(cmd_err), 80'h0);
        check("rst_d_oe", 80'(fsmc_d_oe), 80'h0);
        check("rst_d_o", 80'(fsmc_d_o), 80'h0);
        check("rst_state", 80'(fsm_state), 80'(ST_IDLE));
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < n_vec; i++) begin
            if (vecs[i].is_read) begin
                bus_read(vecs[i].addr, rd, oe_tr);
                check($sformatf("v%0d_rd_a%0d", i, vecs[i].addr), 80'(rd), 80'(vecs[i].exp_rd));
                check($sformatf("v%0d_oe_window", i), 80'(oe_tr), 80'(3'b010));
            end else begin
                bus_write(vecs[i].addr, vecs[i].data, 1'b0, hist, oe_seen);
                check($sformatf("v%0d_tv_timing", i), 80'(hist),
                      vecs[i].exp_pulse ? 80'(8'b0001_0000) : 80'h0);
                check($sformatf("v%0d_temp", i), temp, vecs[i].exp_temp);
                check($sformatf("v%0d_cmd_err", i), 80'(cmd_err), 80'(vecs[i].exp_err));
                check($sformatf("v%0d_wr_oe", i), 80'(oe_seen), 80'h0);
            end
        end

        // both strobes low: write wins, bus never driven
        bus_write(3'd1, 16'h00FF, 1'b1, hist, oe_seen);
        check("both_strobes_oe", 80'(oe_seen), 80'h0);
        check("both_strobes_no_tv", 80'(hist), 80'h0);
        bus_read(3'd1, rd, oe_tr);
        check("both_strobes_shadow1", 80'(rd), 80'h00FF);

        // reset during a read
        @(negedge clk);
        fsmc_a   = 3'd2;
        fsmc_ne  = 1'b0;
        fsmc_noe = 1'b0;
        repeat (4) @(negedge clk);
        check("rd_before_rst_oe", 80'(fsmc_d_oe), 80'h1);
        rst = 1'b0;
        #1;
        check("rd_rst_oe_immediate", 80'(fsmc_d_oe), 80'h0);
        check("rd_rst_d_o", 80'(fsmc_d_o), 80'h0);
        check("rd_rst_temp", temp, 80'h0);
        check("rd_rst_state", 80'(fsm_state), 80'(ST_IDLE));
        @(negedge clk);
        fsmc_ne  = 1'b1;
        fsmc_noe = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // reset during a commit write: the commit must be discarded
        fsmc_a   = 3'd5;
        fsmc_d_i = 16'hA5A5;
        fsmc_ne  = 1'b0;
        fsmc_nwe = 1'b0;
        repeat (3) @(negedge clk);
        check("wr_before_rst_state", 80'(fsm_state), 80'(ST_WR_ACTIVE));
        rst = 1'b0;
        #1;
        check("wr_rst_temp", temp, 80'h0);
        check("wr_rst_state", 80'(fsm_state), 80'(ST_IDLE));
        @(negedge clk);
        fsmc_nwe = 1'b1;
        fsmc_ne  = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        tv_any = 1'b0;
        repeat (8) begin
            @(negedge clk);
            tv_any |= temp_valid;
        end
        check("wr_rst_no_tv", 80'(tv_any), 80'h0);
        check("wr_rst_temp_after", temp, 80'h0);
        check("wr_rst_state_after", 80'(fsm_state), 80'(ST_IDLE));
        bus_read(3'd6, rd, oe_tr);
        check("wr_rst_status", 80'(rd), 80'h0000);

        // commit counter wrap: 256 commits return to 0, the 257th reads 1
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        good_commits = 0;
        for (int i = 0; i < 256; i++) begin
            bus_write(3'd5, 16'hA5A5, 1'b0, hist, oe_seen);
            if (hist == 8'b0001_0000) good_commits++;
        end
        check("wrap_pulses", 80'(good_commits), 80'd256);
        bus_read(3'd6, rd, oe_tr);
        check("wrap_status_256", 80'(rd), 80'(exp_q.pop_front()));
        bus_write(3'd5, 16'hA5A5, 1'b0, hist, oe_seen);
        check("wrap_tv_257", 80'(hist), 80'(8'b0001_0000));
        bus_read(3'd6, rd, oe_tr);
        check("wrap_status_257", 80'(rd), 80'(exp_q.pop_front()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
